// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan controller slice.
// - Default 640x480@60 timing constants (25 MHz pixel clock).
// - Colour channel indices within the packed {R,G,B} pixel word.
// - clog2 helper used to size the scan counters.
// - Flag bundle carried down the sync/blank delay line.
package vga_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_SYNC_START = 659;
  localparam int DEF_H_SYNC_END   = 754;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_SYNC_START = 493;
  localparam int DEF_V_SYNC_END   = 494;
  localparam int DEF_V_TOTAL      = 525;

  // Channel index inside {R,G,B}; field offset of a channel is index*BPC.
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  // Ceiling log2, never less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic hs;   // horizontal sync window, active high
    logic vs;   // vertical sync window, active high
    logic vis;  // visible area
  } scan_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with asynchronous active-low clear.
// DEPTH = 0 degenerates to a wire.
// Ports:
//   vga_clock  pixel clock
//   resetn     asynchronous active-low clear of every stage
//   d_i        data entering stage 1
//   q_o        data leaving stage DEPTH
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             vga_clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // NOTE: these stages are plain flops, not a RAM, so every stage is
      // cleared on reset; that is what keeps sync inactive and blank asserted
      // until real scan data reaches the pins.
      always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// Parametrised VGA scan/timing controller.
// Generates the (x, y) fetch address for a pixel source, then delays sync and
// blank by MEM_LATENCY+1 clocks so they line up with the registered DAC colour.
// Ports:
//   vga_clock, resetn        pixel clock, asynchronous active-low reset
//   pixel_colour             {R,G,B} (or 1 bit in monochrome) for the address
//                            presented MEM_LATENCY clocks earlier
//   x, y, active             fetch address and visible-area decode
//   line_start, frame_start  single-cycle pulses at x==0 / (x,y)==(0,0)
//   VGA_R/G/B                registered DAC colour, blanked outside the picture
//   VGA_HS/VS                active-low sync
//   VGA_BLANK_N, VGA_SYNC_N  DAC blank (0 = blank) and sync-on-green (tied 1)
//   VGA_CLK                  pixel clock forwarded to the DAC
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int BPC          = 2,
  parameter int MONOCHROME   = 0,
  parameter int DAC_WIDTH    = 10,
  parameter int MEM_LATENCY  = 1,
  localparam int XW          = clog2(H_TOTAL),
  localparam int YW          = clog2(V_TOTAL),
  localparam int PIX_W       = (MONOCHROME != 0) ? 1 : 3 * BPC
) (
  input  logic                 vga_clock,
  input  logic                 resetn,
  input  logic [PIX_W-1:0]     pixel_colour,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic                 active,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [DAC_WIDTH-1:0] VGA_R,
  output logic [DAC_WIDTH-1:0] VGA_G,
  output logic [DAC_WIDTH-1:0] VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic                 VGA_CLK
);

  localparam int PIPE_DEPTH = MEM_LATENCY + 1;

  // ---------------------------------------------------------------- counters
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_q == XW'(H_TOTAL - 1)) begin
      x_d = '0;
      y_d = (y_q == YW'(V_TOTAL - 1)) ? '0 : y_q + YW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge value of every other register.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
  assign line_start  = (x_q == '0);
  assign frame_start = (x_q == '0) && (y_q == '0);

  // ------------------------------------------------- fetch-domain flag decode
  scan_flags_t flags_c, flags_q;

  assign flags_c.hs  = (x_q >= XW'(H_SYNC_START)) && (x_q <= XW'(H_SYNC_END));
  assign flags_c.vs  = (y_q >= YW'(V_SYNC_START)) && (y_q <= YW'(V_SYNC_END));
  assign flags_c.vis = active;

  // Sync/blank travel one stage further than the source latency: the extra
  // stage matches the colour register below.
  vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DEPTH)) u_flag_pipe (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .d_i       (flags_c),
    .q_o       (flags_q)
  );

  // Visibility aligned with pixel_colour, i.e. with the cycle the source data
  // for the same address arrives.
  logic vis_tap;

  vga_delay_line #(.WIDTH(1), .DEPTH(MEM_LATENCY)) u_vis_tap (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .d_i       (flags_c.vis),
    .q_o       (vis_tap)
  );

  // -------------------------------------------------------- colour expansion
  logic [2:0][DAC_WIDTH-1:0] dac_c;

  generate
    if (MONOCHROME != 0) begin : g_mono
      assign dac_c = {(3 * DAC_WIDTH){pixel_colour[0]}};
    end else begin : g_colour
      // Channel bits repeat from the DAC MSB downward, so full-scale channel
      // values map to full-scale DAC codes.
      always_comb begin
        dac_c = '0;
        for (int ch = CH_B; ch <= CH_R; ch++) begin
          for (int i = 0; i < DAC_WIDTH; i++) begin
            dac_c[ch][i] = pixel_colour[ch*BPC + (BPC - 1 - ((DAC_WIDTH - 1 - i) % BPC))];
          end
        end
      end
    end
  endgenerate

  logic [2:0][DAC_WIDTH-1:0] rgb_q, rgb_d;

  assign rgb_d = vis_tap ? dac_c : '0;

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) rgb_q <= '0;
    else         rgb_q <= rgb_d;
  end

  // ------------------------------------------------------------------ pins
  assign VGA_R       = rgb_q[CH_R];
  assign VGA_G       = rgb_q[CH_G];
  assign VGA_B       = rgb_q[CH_B];
  assign VGA_HS      = ~flags_q.hs;
  assign VGA_VS      = ~flags_q.vs;
  assign VGA_BLANK_N = flags_q.vis;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_CLK     = vga_clock;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: two instances on a shrunken raster (colour
// BPC=2 / latency 3, and monochrome / latency 0) compared every cycle against
// a position-from-cycle-count model, plus run-length monitors on the syncs.
module tb_vga_scan_controller;

  localparam int HA  = 16;
  localparam int HSS = 19;
  localparam int HSE = 22;
  localparam int HT  = 26;
  localparam int VA  = 10;
  localparam int VSS = 12;
  localparam int VSE = 13;
  localparam int VT  = 15;
  localparam int XW  = $clog2(HT);
  localparam int YW  = $clog2(VT);

  localparam int ML_A = 3;
  localparam int L_A  = ML_A + 1;
  localparam int DW_A = 10;
  localparam int ML_B = 0;
  localparam int L_B  = ML_B + 1;
  localparam int DW_B = 4;

  logic vga_clock = 1'b0;
  logic resetn    = 1'b0;
  always #5 vga_clock = ~vga_clock;

  // ---------------------------------------------------------------- DUT A
  logic [5:0]      pix_a = '0;
  logic [XW-1:0]   x_a;
  logic [YW-1:0]   y_a;
  logic            act_a, ls_a, fs_a, hs_a, vs_a, bn_a, sn_a, ck_a;
  logic [DW_A-1:0] r_a, g_a, b_a;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .BPC(2), .MONOCHROME(0), .DAC_WIDTH(DW_A), .MEM_LATENCY(ML_A)
  ) dut_a (
    .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pix_a),
    .x(x_a), .y(y_a), .active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a), .VGA_CLK(ck_a)
  );

  // ---------------------------------------------------------------- DUT B
  logic [0:0]      pix_b = '0;
  logic [XW-1:0]   x_b;
  logic [YW-1:0]   y_b;
  logic            act_b, ls_b, fs_b, hs_b, vs_b, bn_b, sn_b, ck_b;
  logic [DW_B-1:0] r_b, g_b, b_b;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .BPC(2), .MONOCHROME(1), .DAC_WIDTH(DW_B), .MEM_LATENCY(ML_B)
  ) dut_b (
    .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pix_b),
    .x(x_b), .y(y_b), .active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b), .VGA_CLK(ck_b)
  );

  // ------------------------------------------------------------- checking
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // MSB-aligned repetition: stream copies of the channel until at least dw
  // bits exist, keep the top dw bits.
  function automatic logic [31:0] rep_colour(input logic [31:0] ch, input int bpc, input int dw);
    logic [63:0] acc;
    int n;
    acc = '0;
    n = 0;
    while (n < dw) begin
      acc = (acc << bpc) | 64'(ch);
      n += bpc;
    end
    return 32'(acc >> (n - dw));
  endfunction

  function automatic int pos_x(input int c);
    return c % HT;
  endfunction

  function automatic int pos_y(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic bit visible(input int c);
    return (pos_x(c) < HA) && (pos_y(c) < VA);
  endfunction

  // ta/tb: cycles since reset release (cycle 0 is the one right after it).
  int ta = 0;
  int tb = 0;
  logic [5:0] hist_a [8];
  logic [0:0] hist_b [8];

  always @(negedge vga_clock) begin
    if (!resetn) begin
      check("a_rst_hs", hs_a, 1);
      check("a_rst_vs", vs_a, 1);
      check("a_rst_blank_n", bn_a, 0);
      check("a_rst_rgb", {r_a, g_a, b_a}, 0);
      check("a_rst_xy", {x_a, y_a}, 0);
      ta = 0;
    end else begin
      int t, xt, yt;
      logic [5:0] p;
      hist_a[ta % 8] = pix_a;
      check("a_x", x_a, pos_x(ta));
      check("a_y", y_a, pos_y(ta));
      check("a_active", act_a, visible(ta));
      check("a_line_start", ls_a, pos_x(ta) == 0);
      check("a_frame_start", fs_a, (pos_x(ta) == 0) && (pos_y(ta) == 0));
      check("a_sync_n", sn_a, 1);
      check("a_vga_clk", ck_a, vga_clock);
      if (ta < L_A) begin
        check("a_hs", hs_a, 1);
        check("a_vs", vs_a, 1);
        check("a_blank_n", bn_a, 0);
        check("a_rgb", {r_a, g_a, b_a}, 0);
      end else begin
        t  = ta - L_A;
        xt = pos_x(t);
        yt = pos_y(t);
        p  = hist_a[(ta - 1) % 8];
        check("a_hs", hs_a, !((xt >= HSS) && (xt <= HSE)));
        check("a_vs", vs_a, !((yt >= VSS) && (yt <= VSE)));
        check("a_blank_n", bn_a, visible(t));
        check("a_r", r_a, visible(t) ? rep_colour(32'(p[5:4]), 2, DW_A) : 0);
        check("a_g", g_a, visible(t) ? rep_colour(32'(p[3:2]), 2, DW_A) : 0);
        check("a_b", b_a, visible(t) ? rep_colour(32'(p[1:0]), 2, DW_A) : 0);
      end
      ta++;
    end
  end

  always @(negedge vga_clock) begin
    if (!resetn) begin
      check("b_rst_out", {hs_b, vs_b, bn_b, r_b, g_b, b_b}, {3'b110, 12'd0});
      tb = 0;
    end else begin
      int t;
      logic [31:0] mono;
      hist_b[tb % 8] = pix_b;
      check("b_xy", {x_b, y_b}, {XW'(pos_x(tb)), YW'(pos_y(tb))});
      check("b_flags", {act_b, ls_b, fs_b},
            {visible(tb), pos_x(tb) == 0, (pos_x(tb) == 0) && (pos_y(tb) == 0)});
      if (tb < L_B) begin
        check("b_out", {hs_b, vs_b, bn_b, r_b, g_b, b_b}, {3'b110, 12'd0});
      end else begin
        t = tb - L_B;
        mono = visible(t) ? rep_colour(32'(hist_b[(tb - 1) % 8]), 1, DW_B) : 0;
        check("b_hs", hs_b, !((pos_x(t) >= HSS) && (pos_x(t) <= HSE)));
        check("b_vs", vs_b, !((pos_y(t) >= VSS) && (pos_y(t) <= VSE)));
        check("b_blank_n", bn_b, visible(t));
        check("b_rgb", {r_b, g_b, b_b}, {mono[DW_B-1:0], mono[DW_B-1:0], mono[DW_B-1:0]});
      end
      tb++;
    end
  end

  // Run-length monitors on DUT A, independent of the per-cycle model.
  int mc = 0;
  int last_fs = -1;
  int last_ls = -1;
  int hs_run = 0;
  int vs_run = 0;

  always @(negedge vga_clock) begin
    if (!resetn) begin
      mc = 0; last_fs = -1; last_ls = -1; hs_run = 0; vs_run = 0;
    end else begin
      if (fs_a) begin
        if (last_fs >= 0) check("frame_period", mc - last_fs, HT * VT);
        last_fs = mc;
      end
      if (ls_a) begin
        if (last_ls >= 0) check("line_period", mc - last_ls, HT);
        last_ls = mc;
      end
      if (!hs_a) begin
        if (hs_run == 0 && last_ls >= 0) check("hs_fall_offset", mc - last_ls, HSS + L_A);
        hs_run++;
      end else if (hs_run > 0) begin
        check("hs_low_len", hs_run, HSE - HSS + 1);
        hs_run = 0;
      end
      if (!vs_a) vs_run++;
      else if (vs_run > 0) begin
        check("vs_low_len", vs_run, (VSE - VSS + 1) * HT);
        vs_run = 0;
      end
      mc++;
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    forever begin
      @(posedge vga_clock);
      #1;
      case ($urandom_range(0, 3))
        0:       pix_a = 6'b100111;
        1:       pix_a = 6'b111111;
        default: pix_a = 6'($urandom);
      endcase
      pix_b = 1'($urandom);
    end
  end

  initial begin
    int found;
    // Hand-computed pins on the colour model.
    check("pin_rep_r", rep_colour(32'b10, 2, 10), 32'b1010101010);
    check("pin_rep_g", rep_colour(32'b01, 2, 10), 32'b0101010101);
    check("pin_rep_b", rep_colour(32'b11, 2, 10), 32'b1111111111);
    check("pin_rep_bpc3", rep_colour(32'b101, 3, 10), 32'b1011011011);
    check("pin_rep_mono", rep_colour(32'b1, 1, 4), 32'b1111);

    resetn = 1'b0;
    repeat (3) @(posedge vga_clock);
    #2 resetn = 1'b1;
    repeat (2 * HT * VT + 50) @(posedge vga_clock);

    // Reset in the middle of a visible line.
    found = 0;
    for (int i = 0; i < HT * VT + 5; i++) begin
      @(negedge vga_clock);
      if (x_a == XW'(7) && y_a == YW'(5)) begin
        found = 1;
        break;
      end
    end
    check("reset_point_found", found, 1);
    @(posedge vga_clock);
    #2 resetn = 1'b0;
    repeat (2) @(posedge vga_clock);
    #2 resetn = 1'b1;
    repeat (2 * HT * VT + 10) @(posedge vga_clock);
    @(negedge vga_clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
